timer_input_capture: RTL

//   Memory-mapped timer with input capture. Timestamps edges on an external pin
//   and raises an interrupt to the core. It is the receive-side counterpart of
//   the TIMx output-compare timers: compare drives a pin from a count, capture

---
 rtl/timer_input_capture_if.sv | 33 +++
 rtl/timer_input_capture.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/timer_input_capture_if.sv
// -----------------------------------------------------------------------------
// timer_input_capture_if
//   Peripheral bus bundle for the input-capture timer.
//   bus_addr  : byte address, [3:2] selects one of four registers
//   bus_we    : single-cycle write strobe
//   bus_re    : single-cycle read strobe
//   bus_wdata : write data
//   bus_rdata : registered read data, valid one cycle after bus_re
//   master drives the request side, slave (the timer) returns read data.
// -----------------------------------------------------------------------------
interface timer_input_capture_if;
    logic [3:0]  bus_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_we,
        output bus_re,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_we,
        input  bus_re,
        input  bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/timer_input_capture.sv
// -----------------------------------------------------------------------------
// timer_input_capture
//   Memory-mapped free-running timer that timestamps edges on an external pin
//   and raises a level interrupt.
//   Ports:
//     clk    : system clock
//     reset  : synchronous, active-high reset
//     cap_in : asynchronous capture pin
//     bus    : peripheral bus (slave modport of timer_input_capture_if)
//     irq    : registered level interrupt, IRQEN & (CAPF | OVFF)
//   Registers (byte offsets):
//     0x0 CTRL  [0]EN [2:1]EDGE [3]IRQEN [15:8]PRESC
//     0x4 COUNT counter value, write loads it
//     0x8 CAPT  count latched at the last capture (read-only)
//     0xC STAT  [0]CAPF [1]OVRF [2]OVFF, write-1-to-clear
// -----------------------------------------------------------------------------
module timer_input_capture #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cap_in,
    timer_input_capture_if.slave  bus,
    output logic                  irq
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Register state
    logic                   en_q,       en_d;
    logic [1:0]             edge_sel_q, edge_sel_d;
    logic                   irqen_q,    irqen_d;
    logic [7:0]             presc_q,    presc_d;
    logic [7:0]             pres_cnt_q, pres_cnt_d;
    logic [CNT_W-1:0]       count_q,    count_d;
    logic [CNT_W-1:0]       capt_q,     capt_d;
    logic                   capf_q,     capf_d;
    logic                   ovrf_q,     ovrf_d;
    logic                   ovff_q,     ovff_d;
    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    logic                   pin_q,      pin_d;
    logic [31:0]            rdata_q,    rdata_d;
    logic                   irq_q,      irq_d;

    // Decoded strobes and events
    logic [1:0]  sel_s;
    logic        wr_ctrl_s, wr_count_s, wr_stat_s;
    logic        pin_sync_s, rise_s, fall_s, cap_evt_s;
    logic        tick_s, ovf_set_s;
    logic [31:0] count_rd_s, capt_rd_s, rd_mux_s;
    logic        unused_s;

    assign sel_s      = bus.bus_addr[3:2];
    assign wr_ctrl_s  = bus.bus_we & (sel_s == 2'd0);
    assign wr_count_s = bus.bus_we & (sel_s == 2'd1);
    assign wr_stat_s  = bus.bus_we & (sel_s == 2'd3);

    // The edge flop holds the previous synchronized sample, so an edge is seen
    // SYNC_STAGES clocks after the pin is first sampled.
    assign pin_sync_s = sync_q[SYNC_STAGES-1];
    assign rise_s     = pin_sync_s & ~pin_q;
    assign fall_s     = ~pin_sync_s & pin_q;
    assign cap_evt_s  = en_q & ((rise_s & edge_sel_q[0]) | (fall_s & edge_sel_q[1]));

    assign tick_s     = en_q & (pres_cnt_q == presc_q);
    // A COUNT write in the wrap cycle suppresses the overflow flag.
    assign ovf_set_s  = tick_s & (&count_q) & ~wr_count_s;

    assign unused_s   = ^{bus.bus_addr[1:0], bus.bus_wdata};

    // Next-state logic for all registers and the read mux
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], cap_in};
        pin_d  = pin_sync_s;

        if (wr_ctrl_s) begin
            en_d       = bus.bus_wdata[0];
            edge_sel_d = bus.bus_wdata[2:1];
            irqen_d    = bus.bus_wdata[3];
            presc_d    = bus.bus_wdata[15:8];
        end else begin
            en_d       = en_q;
            edge_sel_d = edge_sel_q;
            irqen_d    = irqen_q;
            presc_d    = presc_q;
        end

        if (wr_ctrl_s | wr_count_s) begin
            pres_cnt_d = 8'd0;
        end else if (tick_s) begin
            pres_cnt_d = 8'd0;
        end else if (en_q) begin
            pres_cnt_d = pres_cnt_q + 8'd1;
        end else begin
            pres_cnt_d = pres_cnt_q;
        end

        if (wr_count_s) begin
            count_d = bus.bus_wdata[CNT_W-1:0];
        end else if (tick_s) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end

        // CAPT takes the count as it stood before any same-cycle update.
        if (cap_evt_s) begin
            capt_d = count_q;
        end else begin
            capt_d = capt_q;
        end

        // Status flags: a same-cycle set beats the write-1-to-clear.
        if (cap_evt_s) begin
            capf_d = 1'b1;
        end else if (wr_stat_s & bus.bus_wdata[0]) begin
            capf_d = 1'b0;
        end else begin
            capf_d = capf_q;
        end

        if (cap_evt_s & capf_q) begin
            ovrf_d = 1'b1;
        end else if (wr_stat_s & bus.bus_wdata[1]) begin
            ovrf_d = 1'b0;
        end else begin
            ovrf_d = ovrf_q;
        end

        if (ovf_set_s) begin
            ovff_d = 1'b1;
        end else if (wr_stat_s & bus.bus_wdata[2]) begin
            ovff_d = 1'b0;
        end else begin
            ovff_d = ovff_q;
        end

        irq_d = irqen_q & (capf_q | ovff_q);

        count_rd_s            = 32'd0;
        count_rd_s[CNT_W-1:0] = count_q;
        capt_rd_s             = 32'd0;
        capt_rd_s[CNT_W-1:0]  = capt_q;

        // Reads see the register image before any same-cycle write.
        case (sel_s)
            2'd0:    rd_mux_s = {16'd0, presc_q, 4'd0, irqen_q, edge_sel_q, en_q};
            2'd1:    rd_mux_s = count_rd_s;
            2'd2:    rd_mux_s = capt_rd_s;
            2'd3:    rd_mux_s = {29'd0, ovff_q, ovrf_q, capf_q};
            default: rd_mux_s = 32'd0;
        endcase

        if (bus.bus_re) begin
            rdata_d = rd_mux_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            edge_sel_q <= 2'd0;
            irqen_q    <= 1'b0;
            presc_q    <= 8'd0;
            pres_cnt_q <= 8'd0;
            count_q    <= {CNT_W{1'b0}};
            capt_q     <= {CNT_W{1'b0}};
            capf_q     <= 1'b0;
            ovrf_q     <= 1'b0;
            ovff_q     <= 1'b0;
            sync_q     <= {SYNC_STAGES{1'b0}};
            pin_q      <= 1'b0;
            rdata_q    <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            edge_sel_q <= edge_sel_d;
            irqen_q    <= irqen_d;
            presc_q    <= presc_d;
            pres_cnt_q <= pres_cnt_d;
            count_q    <= count_d;
            capt_q     <= capt_d;
            capf_q     <= capf_d;
            ovrf_q     <= ovrf_d;
            ovff_q     <= ovff_d;
            sync_q     <= sync_d;
            pin_q      <= pin_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.bus_rdata = rdata_q;
    assign irq           = irq_q;
endmodule
